// File: rtl/tick_pkg.sv
// Shared speed codes, run-state encoding and reload computation for the tick controller.
package tick_pkg;

    localparam logic [1:0] SPD_FULL    = 2'b00;
    localparam logic [1:0] SPD_1HZ     = 2'b01;
    localparam logic [1:0] SPD_HALF    = 2'b10;
    localparam logic [1:0] SPD_QUARTER = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } run_state_t;

    // Reload value (period-1) in a wide word; callers narrow it to their countdown width.
    function automatic logic [63:0] period_of(input logic [1:0] code, input logic [63:0] clk_hz);
        logic [63:0] reload;
        case (code)
            SPD_FULL: reload = 64'd0;
            SPD_1HZ:  reload = clk_hz - 64'd1;
            SPD_HALF: reload = (clk_hz << 1) - 64'd1;
            default:  reload = (clk_hz << 2) - 64'd1;
        endcase
        return reload;
    endfunction

endpackage

// File: rtl/tick_controller_key_debouncer.sv
// Synchronises and debounces the active-low run key; emits a one-cycle pulse per accepted press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          key_p0;
    logic          key_p1;
    logic          level;
    logic [DW-1:0] stable_cnt;

    // sync stage: two flops, released level is 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
        end
    end

    // debounce stage: level flips only after the key disagrees for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_p1 != level) begin
                if (stable_cnt == LAST) begin
                    level      <= key_p1;
                    stable_cnt <= '0;
                    press      <= ~key_p1;
                end else begin
                    stable_cnt <= stable_cnt + DW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tick_controller.sv
// Rate-selectable one-cycle enable pulse generator with a debounced run/pause key.
module tick_controller
    import tick_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 28
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] speed_sel,
    input  logic       run_key_n,
    output logic       tick,
    output logic       running,
    output logic [1:0] cur_speed
);

    localparam logic [CNT_W-1:0] RL_FULL    = CNT_W'(period_of(SPD_FULL,    64'(CLK_HZ)));
    localparam logic [CNT_W-1:0] RL_1HZ     = CNT_W'(period_of(SPD_1HZ,     64'(CLK_HZ)));
    localparam logic [CNT_W-1:0] RL_HALF    = CNT_W'(period_of(SPD_HALF,    64'(CLK_HZ)));
    localparam logic [CNT_W-1:0] RL_QUARTER = CNT_W'(period_of(SPD_QUARTER, 64'(CLK_HZ)));

    logic [1:0]       speed_p0;
    logic [1:0]       speed_p1;
    logic             press;
    run_state_t       state;
    run_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [1:0]       speed_next;
    logic [1:0]       code_sel;
    logic [CNT_W-1:0] reload;
    logic             speed_change;
    logic             started;

    // speed sync stage: two flops ahead of the cur_speed register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            speed_p0 <= '0;
            speed_p1 <= '0;
        end else begin
            speed_p0 <= speed_sel;
            speed_p1 <= speed_p0;
        end
    end

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk    (clk),
        .reset_n(reset_n),
        .key_n  (run_key_n),
        .press  (press)
    );

    // started keeps tick low while reset is held and until the first edge after release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            count     <= '0;
            cur_speed <= SPD_FULL;
            started   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            cur_speed <= speed_next;
            started   <= 1'b1;
        end
    end

    always_comb begin
        speed_change = (speed_p1 != cur_speed);
        code_sel     = speed_change ? speed_p1 : cur_speed;
        case (code_sel)
            SPD_FULL: reload = RL_FULL;
            SPD_1HZ:  reload = RL_1HZ;
            SPD_HALF: reload = RL_HALF;
            default:  reload = RL_QUARTER;
        endcase
    end

    always_comb begin
        state_next = state;
        count_next = count;
        speed_next = cur_speed;
        tick       = 1'b0;

        if (press) begin
            state_next = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end

        // A speed change wins over counting: reload and suppress the tick even in RUN
        if (speed_change) begin
            speed_next = speed_p1;
            count_next = reload;
        end else if (state == ST_RUN && started) begin
            if (count == '0) begin
                tick       = 1'b1;
                count_next = reload;
            end else begin
                count_next = count - CNT_W'(1);
            end
        end
    end

    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_tick_controller.sv
// Scenario bench for tick_controller at CLK_HZ=8, DEBOUNCE_CYCLES=4, CNT_W=6.
module tb_tick_controller;

    logic       clk;
    logic       reset_n;
    logic [1:0] speed_sel;
    logic       run_key_n;
    logic       tick;
    logic       running;
    logic [1:0] cur_speed;

    int total;
    int bad;
    int n;
    logic [3:0] exp_q[$];

    tick_controller #(
        .CLK_HZ(8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(6)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .speed_sel(speed_sel),
        .run_key_n(run_key_n),
        .tick     (tick),
        .running  (running),
        .cur_speed(cur_speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance();
        @(posedge clk);
        #1;
        n = n + 1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        logic [3:0] got;
        reset_n   = 1'b0;
        speed_sel = 2'b00;
        run_key_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        got = {tick, running, cur_speed};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("FAIL reset_hold got tick/run/spd=%b required=%b", got, 4'b0100);
        end
        reset_n = 1'b1;
        n = 0;
        #1;
        got = {tick, running, cur_speed};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("FAIL reset_release got tick/run/spd=%b required=%b", got, 4'b0100);
        end
        while (n < 5) begin
            exp_q.push_back(4'b1100);
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_full_rate n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
    endtask

    task automatic test_speed();
        logic [3:0] e;
        logic [3:0] got;
        int m;
        logic t;
        logic [1:0] c;
        while (n < 97) begin
            if (n == 5)  speed_sel = 2'b01;
            if (n == 31) speed_sel = 2'b11;
            m = n + 1;
            c = (m < 8) ? 2'b00 : (m < 34) ? 2'b01 : 2'b11;
            t = (m == 6) ||
                (m >= 15 && m < 34 && ((m - 15) % 8) == 0) ||
                (m >= 65 && ((m - 65) % 32) == 0);
            exp_q.push_back({t, 1'b1, c});
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL speed n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] e;
        logic [3:0] got;
        while (n < 107) begin
            if (n == 97)  run_key_n = 1'b0;
            if (n == 100) run_key_n = 1'b1;
            exp_q.push_back(4'b0111);
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL glitch n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic [3:0] e;
        logic [3:0] got;
        int m;
        logic r;
        while (n < 185) begin
            if (n == 107) run_key_n = 1'b0;
            if (n == 117) run_key_n = 1'b1;
            if (n == 137) run_key_n = 1'b0;
            if (n == 147) run_key_n = 1'b1;
            m = n + 1;
            r = (m < 114) || (m >= 144);
            exp_q.push_back({(m == 159), r, 2'b11});
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL pause_resume n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
    endtask

    task automatic test_press_with_speed();
        logic [3:0] e;
        logic [3:0] got;
        int m;
        while (n < 197) begin
            if (n == 185) run_key_n = 1'b0;
            if (n == 189) speed_sel = 2'b10;
            if (n == 195) run_key_n = 1'b1;
            m = n + 1;
            exp_q.push_back((m < 192) ? 4'b0111 : 4'b0010);
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL press_with_speed n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
    endtask

    task automatic test_speed_while_paused();
        logic [3:0] e;
        logic [3:0] got;
        int m;
        logic t;
        while (n < 240) begin
            if (n == 197) speed_sel = 2'b01;
            if (n == 207) run_key_n = 1'b0;
            if (n == 217) run_key_n = 1'b1;
            m = n + 1;
            t = (m == 221) || (m == 229) || (m == 237);
            exp_q.push_back({t, (m >= 214), (m < 200) ? 2'b10 : 2'b01});
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL speed_while_paused n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        logic [3:0] got;
        int m;
        while (n < 248) begin
            if (n == 240) speed_sel = 2'b11;
            m = n + 1;
            exp_q.push_back({2'b01, (m < 243) ? 2'b01 : 2'b11});
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL pre_reset n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
        #3;
        reset_n = 1'b0;
        #1;
        got = {tick, running, cur_speed};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("FAIL async_reset_mid_count got tick/run/spd=%b required=%b", got, 4'b0100);
        end
        speed_sel = 2'b00;
        #2;
        reset_n = 1'b1;
        n = 0;
        #1;
        got = {tick, running, cur_speed};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("FAIL rerelease got tick/run/spd=%b required=%b", got, 4'b0100);
        end
        while (n < 3) begin
            exp_q.push_back(4'b1100);
            advance();
            got = {tick, running, cur_speed};
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL rerelease_ticks n=%0d got tick/run/spd=%b required=%b", n, got, e);
            end
        end
        #3;
        reset_n = 1'b0;
        #1;
        got = {tick, running, cur_speed};
        total++;
        if (got !== 4'b0100) begin
            bad++;
            $display("FAIL async_reset_tick_drop got tick/run/spd=%b required=%b", got, 4'b0100);
        end
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n     = 0;
        test_reset();
        test_speed();
        test_glitch();
        test_pause_resume();
        test_press_with_speed();
        test_speed_while_paused();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
